avaliador_credito: RTL

- Front end of the credit-evaluation path. Samples a requested instalment (parcela) against declared income (renda) when the user presses solicitar.
- Classifies the request and drives the one-hot status triple aceito/comprometido/recusado consumed by the 7-segment/buzzer decoder.
- Holds the result for a fixed display time, then blanks.
- Includes button synchronisation, edge detection, a 4-state FSM and a hold counter.

---
 rtl/avaliador_pkg.sv | 13 +
 rtl/sincronizador_borda.sv | 17 +
 rtl/avaliador_credito.sv | 92 +++++++++
 3 files changed

// File: rtl/avaliador_pkg.sv
// avaliador_pkg: FSM state encoding and affordability thresholds shared by the credit evaluator.
package avaliador_pkg;
    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        AMOSTRA = 2'd1,
        AVALIA  = 2'd2,
        EXIBE   = 2'd3
    } estado_t;
    localparam int unsigned ACEITO_NUM = 3;
    localparam int unsigned ACEITO_DEN = 10;
    localparam int unsigned COMP_NUM   = 1;
    localparam int unsigned COMP_DEN   = 2;
endpackage

// File: rtl/sincronizador_borda.sv
// sincronizador_borda: two-flop synchroniser plus one-cycle rising-edge pulse for a raw button.
module sincronizador_borda #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic pulso
);
    logic [2:0] s_q, s_d;
    always_comb s_d = {s_q[1:0], din};
    always_ff @(posedge clock or posedge reset) begin
        if (reset) s_q <= {3{RST_VAL}};
        else       s_q <= s_d;
    end
    assign pulso = s_q[1] & ~s_q[2];
endmodule

// File: rtl/avaliador_credito.sv
// avaliador_credito: samples parcela/renda on a button press, classifies the instalment ratio
// and holds a one-hot A/C/r result for HOLD_CYCLES clocks.
module avaliador_credito
    import avaliador_pkg::*;
#(
    parameter int W           = 8,
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         solicitar,
    input  logic [W-1:0] renda,
    input  logic [W-1:0] parcela,
    output logic         aceito,
    output logic         comprometido,
    output logic         recusado,
    output logic         ocupado
);
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_INI = CW'(HOLD_CYCLES - 1);
    localparam logic [W+3:0]   AN = (W+4)'(ACEITO_NUM);
    localparam logic [W+3:0]   AD = (W+4)'(ACEITO_DEN);
    localparam logic [W+3:0]   CN = (W+4)'(COMP_NUM);
    localparam logic [W+3:0]   CD = (W+4)'(COMP_DEN);

    logic          req;
    estado_t       estado_q, estado_d;
    logic [W-1:0]  renda_q, renda_d, parcela_q, parcela_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    res_q, res_d, classe;
    logic [W+3:0]  r_ext, p_ext;

    sincronizador_borda #(.RST_VAL(1'b1)) u_sync (
        .clock (clock),
        .reset (reset),
        .din   (solicitar),
        .pulso (req)
    );

    // W+4 bits hold parcela*10 for any W-bit parcela, so the compares never wrap
    always_comb begin
        r_ext  = (W+4)'(renda_q);
        p_ext  = (W+4)'(parcela_q);
        classe = (p_ext * AD <= r_ext * AN) ? 3'b100 :
                 (p_ext * CD <= r_ext * CN) ? 3'b010 : 3'b001;
    end

    always_comb begin
        estado_d  = estado_q;
        renda_d   = renda_q;
        parcela_d = parcela_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        case (estado_q)
            OCIOSO:  estado_d = req ? AMOSTRA : OCIOSO;
            AMOSTRA: begin
                renda_d   = renda;
                parcela_d = parcela;
                estado_d  = AVALIA;
            end
            AVALIA: begin
                res_d    = classe;
                cnt_d    = CNT_INI;
                estado_d = EXIBE;
            end
            EXIBE: begin
                estado_d = req ? AMOSTRA : (cnt_q == '0) ? OCIOSO : EXIBE;
                res_d    = (req || cnt_q == '0) ? 3'b000 : res_q;
                cnt_d    = (req || cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q  <= OCIOSO;
            renda_q   <= '0;
            parcela_q <= '0;
            cnt_q     <= '0;
            res_q     <= '0;
        end else begin
            estado_q  <= estado_d;
            renda_q   <= renda_d;
            parcela_q <= parcela_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
        end
    end

    assign {aceito, comprometido, recusado} = res_q;
    assign ocupado = (estado_q != OCIOSO);
endmodule
